wptr_full_ctrl: RTL and testbench

Write-side pointer and status controller for the asynchronous FIFO, in the write clock domain, directly upstream of the dual-port memory. It accepts write requests and produces the memory write address and the registered full flag that gate memory writes. It also synchronizes the read-domain Gray pointer and reports almost-full, fill level and a sticky overflow. It exports its own Gray write pointer to the read domain.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_r2w.sv | 23 ++
 rtl/wptr_full_ctrl.sv | 78 +++++++
 tb/tb_wptr_full_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and Gray/binary conversion helpers
package fifo_pkg;

    localparam int ASIZE_DEFAULT = 4;
    localparam int PTRW          = ASIZE_DEFAULT + 1;
    localparam int MAXW          = 32;

    typedef logic [MAXW-1:0] word_t;

    // Width-agnostic: callers zero-extend into word_t and truncate the result.
    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = g;
        for (int i = 1; i < MAXW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_r2w.sv
// rtl/sync_r2w.sv - two-flop pointer synchronizer into the local clock domain
module sync_r2w #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write pointer, full/almost-full, level and overflow for the async FIFO
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ASIZE        = ASIZE_DEFAULT,
    parameter int AFULL_THRESH = 12
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr,
    input  logic             wovf_clr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    localparam int PW = ASIZE + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] wlevel_next;
    logic          accepted;
    logic          wfull_next;
    word_t         gray_w;
    word_t         rbin_w;

    sync_r2w #(.W(PW)) u_sync_r2w (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr),
        .q     (wq2_rptr)
    );

    always_comb begin
        accepted    = winc && !wfull;
        wbinnext    = wbin + PW'(accepted);
        gray_w      = bin2gray(word_t'(wbinnext));
        wgraynext   = gray_w[PW-1:0];
        rbin_w      = gray2bin(word_t'(wq2_rptr));
        rbin_s      = rbin_w[PW-1:0];
        // Levels are computed against the synchronized (stale) read pointer, so they only overestimate.
        wlevel_next = wbinnext - rbin_s;
        wfull_next  = (wgraynext == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            walmost_full <= (wlevel_next >= AFULL_LVL);
            wlevel       <= wlevel_next;
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

    assign waddr = wbin[ASIZE-1:0];

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - self-checking bench for wptr_full_ctrl against a counting occupancy model
module tb_wptr_full_ctrl;

    localparam int ASIZE = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic             wclk = 1'b0;
    logic             wrst_n = 1'b0;
    logic             winc = 1'b0;
    logic [ASIZE:0]   rptr = '0;
    logic             wovf_clr = 1'b0;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr;
    logic             wfull;
    logic             walmost_full;
    logic [ASIZE:0]   wlevel;
    logic             woverflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: unbounded write/read counts; synchronizer seen as a two-edge delay of the read count.
    int  wcount = 0;
    int  rd_count = 0;
    int  rd_d1 = 0;
    int  rd_d2 = 0;
    int  m_level = 0;
    bit  m_full = 0;
    bit  m_ovf = 0;
    logic [ASIZE:0] prev_wptr;

    wptr_full_ctrl #(.ASIZE(ASIZE), .AFULL_THRESH(AFULL)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr         (rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [ASIZE:0] gray_of(input int count);
        logic [ASIZE:0] b;
        b = ASIZE'(count % (2 * DEPTH));
        b = (ASIZE + 1)'(count % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".waddr"}, 32'(waddr), 32'(wcount % DEPTH));
        chk({tag, ".wptr"}, 32'(wptr), 32'(gray_of(wcount)));
        chk({tag, ".wfull"}, 32'(wfull), 32'(m_full));
        chk({tag, ".wlevel"}, 32'(wlevel), 32'(m_level));
        chk({tag, ".afull"}, 32'(walmost_full), 32'(m_level >= AFULL));
        chk({tag, ".wovf"}, 32'(woverflow), 32'(m_ovf));
    endtask

    task automatic step(input bit w, input bit r, input bit c, input string tag);
        bit acc;
        @(negedge wclk);
        if (r && rd_count < wcount) rd_count++;
        winc     = w;
        wovf_clr = c;
        rptr     = gray_of(rd_count);
        prev_wptr = wptr;
        @(posedge wclk);
        acc = w && !m_full;
        if (w && m_full) m_ovf = 1;
        else if (c) m_ovf = 0;
        wcount  += int'(acc);
        m_level = wcount - rd_d2;
        m_full  = (m_level == DEPTH);
        rd_d2   = rd_d1;
        rd_d1   = rd_count;
        #1;
        check_all(tag);
        if (acc) chk({tag, ".gray1bit"}, 32'($countones(prev_wptr ^ wptr)), 32'd1);
    endtask

    task automatic do_reset(input int edges, input string tag);
        @(negedge wclk);
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wovf_clr = 1'b0;
        rptr     = '0;
        repeat (edges) @(posedge wclk);
        wcount = 0; rd_count = 0; rd_d1 = 0; rd_d2 = 0;
        m_level = 0; m_full = 0; m_ovf = 0;
        #1;
        check_all(tag);
        @(negedge wclk);
        wrst_n = 1'b1;
        winc   = 1'b0;
    endtask

    initial begin
        // Reset held two edges with winc high
        do_reset(2, "reset");

        // Fill 16 entries with rptr at 0
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, "fill");
        chk("fill.full_at_16", 32'(wfull), 32'd1);
        chk("fill.level_16", 32'(wlevel), 32'd16);

        // Overflow attempt, then clear colliding with a new attempt, then clear alone
        step(1, 0, 0, "ovf_try");
        chk("ovf.set", 32'(woverflow), 32'd1);
        step(1, 0, 1, "ovf_setwins");
        chk("ovf.setwins", 32'(woverflow), 32'd1);
        step(0, 0, 1, "ovf_clr");
        chk("ovf.cleared", 32'(woverflow), 32'd0);

        // Release latency: one read before edge M, wfull drops at M+2
        step(0, 1, 0, "rel_M");
        chk("rel.M_full", 32'(wfull), 32'd1);
        step(0, 0, 0, "rel_M1");
        chk("rel.M1_full", 32'(wfull), 32'd1);
        step(0, 0, 0, "rel_M2");
        chk("rel.M2_full", 32'(wfull), 32'd0);
        chk("rel.M2_level", 32'(wlevel), 32'd15);

        // Wrap: 40 writes with reads kept two behind
        do_reset(1, "reset2");
        for (int i = 0; i < 40; i++) step(1, (wcount - rd_count) > 2, 0, "wrap");
        chk("wrap.count", 32'(wcount), 32'd40);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), "rand");

        // Mid-operation reset with level 9 and overflow set
        do_reset(1, "reset3");
        for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, "pre_fill");
        for (int i = 0; i < 7; i++) step(0, 1, 0, "pre_read");
        step(0, 0, 0, "pre_idle");
        step(0, 0, 0, "pre_idle");
        chk("mid.level9", 32'(wlevel), 32'd9);
        chk("mid.ovf1", 32'(woverflow), 32'd1);
        do_reset(1, "midreset");
        step(1, 0, 0, "post_reset_write");
        chk("mid.next_waddr", 32'(waddr), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
